// File: rtl/bw_zzctu_sync_vec.sv
// bw_zzctu_sync_vec: WIDTH-bit DEPTH-stage scannable synchroniser with rise/fall pulses; optional stability filter under BW_ZZCTU_SYNC_FILT_EN
module bw_zzctu_sync_vec #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int FILT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             se,
    input  logic             si,
    output logic             so,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);
    logic [DEPTH-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q_nxt;
    if (WIDTH < 1 || DEPTH < 2 || FILT < 1) begin : g_param_chk
        $error("bw_zzctu_sync_vec: WIDTH>=1, DEPTH>=2, FILT>=1 required");
    end
    assign s = sync[DEPTH-1];
    assign so = q[WIDTH-1];
`ifdef BW_ZZCTU_SYNC_FILT_EN
    localparam int CW = FILT > 1 ? $clog2(FILT) : 1;
    localparam int N = WIDTH * (DEPTH + 2);
    localparam logic [CW-1:0] CMAX = CW'(FILT - 1);
    logic [WIDTH-1:0] cand;
    logic [CW-1:0] cnt;
    assign q_nxt = (s == cand && cnt == CMAX) ? cand : q;
    assign stable = cnt == CMAX && cand == q;
    // sync chain, candidate word qualified by a saturating hold counter, then q and edge pulses; scan shifts sync->cand->q
    always_ff @(posedge clk)
        if (rst) begin
            {q, cand, sync} <= '0;
            cnt <= '0;
            rise <= '0;
            fall <= '0;
        end else if (se) begin
            {q, cand, sync} <= N'({q, cand, sync, si});
            rise <= '0;
            fall <= '0;
        end else begin
            sync <= {sync[DEPTH-2:0], d};
            cand <= s;
            cnt <= (s != cand) ? '0 : (cnt == CMAX) ? cnt : cnt + 1'b1;
            q <= q_nxt;
            rise <= q_nxt & ~q;
            fall <= ~q_nxt & q;
        end
`else
    localparam int N = WIDTH * (DEPTH + 1);
    assign q_nxt = s;
    assign stable = s == q;
    // sync chain straight into q with edge pulses; scan shifts sync->q
    always_ff @(posedge clk)
        if (rst) begin
            {q, sync} <= '0;
            rise <= '0;
            fall <= '0;
        end else if (se) begin
            {q, sync} <= N'({q, sync, si});
            rise <= '0;
            fall <= '0;
        end else begin
            sync <= {sync[DEPTH-2:0], d};
            q <= q_nxt;
            rise <= q_nxt & ~q;
            fall <= ~q_nxt & q;
        end
`endif
endmodule
